// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage
//   EX/MEM pipeline register sitting directly behind the 16-bit ALU. It also
//   owns the architectural flag register {N,V,Z} and resolves conditional
//   branches against it, producing a registered redirect for the PC logic.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   stall                 hold every register in this stage
//   flush                 turn the incoming instruction into a bubble
//   ex_*                  instruction and control at the ALU output
//   mem_*                 registered instruction and control for the MEM stage
//   flags_q               flag register {N,V,Z}
//   br_taken, br_target   registered branch redirect (one-cycle pulse)
module ex_mem_flag_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned REG_W    = 4,
  parameter logic [2:0]  FLAG_RST = 3'b000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [3:0]        ex_ALUop,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [2:0]        ex_flags,
  input  logic              ex_br,
  input  logic [2:0]        ex_cond,
  input  logic [DATA_W-1:0] ex_br_target,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_we,
  input  logic              ex_mem_re,
  input  logic              ex_mem_we,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_we,
  output logic              mem_mem_re,
  output logic              mem_mem_we,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [2:0]        flags_q,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;

  // Branch condition against flags f = {N,V,Z}.
  function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] f);
    logic n, v, z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (cond)
      3'b000:  cond_true = ~z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = ~z & ~n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = ~n;
      3'b101:  cond_true = n | z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  endfunction

  // Next flag value for a captured non-branch instruction.
  function automatic logic [2:0] next_flags(input logic [3:0] op,
                                            input logic [2:0] cur,
                                            input logic [2:0] alu);
    case (op)
      OP_ADD, OP_SUB:                         next_flags = alu;
      OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: next_flags = {cur[2:1], alu[0]};
      default:                                next_flags = cur;
    endcase
  endfunction

  logic capture;
  assign capture = ex_valid & ~flush;

  // EX -> MEM boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_we         <= 1'b0;
      mem_mem_re     <= 1'b0;
      mem_mem_we     <= 1'b0;
      mem_store_data <= '0;
      flags_q        <= FLAG_RST;
      br_taken       <= 1'b0;
      br_target      <= '0;
    end else if (!stall) begin
      if (!capture) begin
        // Bubble: clear valid and enables, data fields simply hold.
        mem_valid  <= 1'b0;
        mem_we     <= 1'b0;
        mem_mem_re <= 1'b0;
        mem_mem_we <= 1'b0;
        br_taken   <= 1'b0;
      end else begin
        mem_valid      <= 1'b1;
        mem_result     <= ex_result;
        mem_rd         <= ex_rd;
        mem_we         <= ex_we;
        mem_mem_re     <= ex_mem_re;
        mem_mem_we     <= ex_mem_we;
        mem_store_data <= ex_store_data;
        // Branches read flags_q as left by older instructions and never write it.
        br_taken       <= ex_br & cond_true(ex_cond, flags_q);
        if (ex_br) begin
          br_target <= ex_br_target;
        end else begin
          flags_q <= next_flags(ex_ALUop, flags_q, ex_flags);
        end
      end
    end
  end

endmodule
